// File: rtl/matrix_mult_ctrl_if.sv
// Control/memory bus between matrix_mult_ctrl and the matrix store.
// master = controller side, slave = memory/requester side.
interface matrix_mult_ctrl_if;
   logic       start;
   logic       busy;
   logic       done;
   logic [1:0] mem_matrix_select;
   logic [1:0] mem_row;
   logic [1:0] mem_col;
   logic       mem_write_enable;
   logic [7:0] mem_write_data;
   logic [7:0] mem_read_data;

   modport master (
      input  start, mem_read_data,
      output busy, done, mem_matrix_select, mem_row, mem_col,
             mem_write_enable, mem_write_data
   );

   modport slave (
      output start, mem_read_data,
      input  busy, done, mem_matrix_select, mem_row, mem_col,
             mem_write_enable, mem_write_data
   );
endinterface

// File: rtl/matrix_mult_ctrl.sv
// Sequential NxN byte matrix multiply controller: C = A x B over a shared memory port.
// Define MATRIX_MULT_SATURATE_EN to clamp result bytes at 8'hFF instead of truncating.
module matrix_mult_ctrl #(
   parameter int N     = 3,
   parameter int SRC_A = 0,
   parameter int SRC_B = 1,
   parameter int DST   = 2
) (
   input logic               clk,
   input logic               reset,
   matrix_mult_ctrl_if.master bus
);
   localparam logic [1:0] LAST = 2'(N - 1);
   localparam logic [1:0] SEL_A = 2'(SRC_A);
   localparam logic [1:0] SEL_B = 2'(SRC_B);
   localparam logic [1:0] SEL_C = 2'(DST);

   typedef enum logic [2:0] {IDLE, READ_A, READ_B, WRITE, DONE} state_t;

   state_t      state;
   logic [1:0]  i, j, k;
   logic [7:0]  a_reg;
   logic [17:0] acc;
   logic [15:0] prod;
   logic [17:0] acc_sum;
   logic [7:0]  result;

   assign prod    = 16'(a_reg) * 16'(bus.mem_read_data);
   assign acc_sum = acc + 18'(prod);

`ifdef MATRIX_MULT_SATURATE_EN
   assign result = (acc_sum > 18'd255) ? 8'hFF : acc_sum[7:0];
`else
   assign result = acc_sum[7:0];
`endif

   // Outputs are loaded together with the state they belong to, so every
   // output is a flop and never follows mem_read_data combinationally.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state                 <= IDLE;
         i                     <= '0;
         j                     <= '0;
         k                     <= '0;
         a_reg                 <= '0;
         acc                   <= '0;
         bus.busy              <= 1'b0;
         bus.done              <= 1'b0;
         bus.mem_matrix_select <= '0;
         bus.mem_row           <= '0;
         bus.mem_col           <= '0;
         bus.mem_write_enable  <= 1'b0;
         bus.mem_write_data    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  state                 <= READ_A;
                  i                     <= '0;
                  j                     <= '0;
                  k                     <= '0;
                  acc                   <= '0;
                  bus.busy              <= 1'b1;
                  bus.mem_matrix_select <= SEL_A;
                  bus.mem_row           <= '0;
                  bus.mem_col           <= '0;
               end
            end
            READ_A: begin
               a_reg                 <= bus.mem_read_data;
               state                 <= READ_B;
               bus.mem_matrix_select <= SEL_B;
               bus.mem_row           <= k;
               bus.mem_col           <= j;
            end
            READ_B: begin
               acc <= acc_sum;
               if (k < LAST) begin
                  k                     <= k + 2'd1;
                  state                 <= READ_A;
                  bus.mem_matrix_select <= SEL_A;
                  bus.mem_row           <= i;
                  bus.mem_col           <= k + 2'd1;
               end else begin
                  state                 <= WRITE;
                  bus.mem_matrix_select <= SEL_C;
                  bus.mem_row           <= i;
                  bus.mem_col           <= j;
                  bus.mem_write_enable  <= 1'b1;
                  bus.mem_write_data    <= result;
               end
            end
            WRITE: begin
               acc                  <= '0;
               k                    <= '0;
               bus.mem_write_enable <= 1'b0;
               bus.mem_write_data   <= '0;
               if (j < LAST || i < LAST) begin
                  state                 <= READ_A;
                  bus.mem_matrix_select <= SEL_A;
                  bus.mem_col           <= '0;
                  if (j < LAST) begin
                     j           <= j + 2'd1;
                     bus.mem_row <= i;
                  end else begin
                     j           <= '0;
                     i           <= i + 2'd1;
                     bus.mem_row <= i + 2'd1;
                  end
               end else begin
                  state                 <= DONE;
                  bus.done              <= 1'b1;
                  bus.mem_matrix_select <= '0;
                  bus.mem_row           <= '0;
                  bus.mem_col           <= '0;
               end
            end
            DONE: begin
               state    <= IDLE;
               bus.done <= 1'b0;
               bus.busy <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
